// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter that sits on the CPU data-RAM bus.
// TXDATA (BASEADDR) queues a byte into a small FIFO. STATUS (BASEADDR+1)
// reports the FIFO and FSM state and a sticky overflow flag.
// Bus read data is registered, and sel_o tells the top-level mux to use it.
//
// Bus handshake: no valid/ready. A write is taken on the edge where wr_i=1.
// A read presents data_o/sel_o exactly one cycle after the edge where rd_i=1.
// A TXDATA write that arrives while the FIFO is full is dropped and sets
// overflow. The exception is a cycle in which the transmitter pops: then
// the write is accepted.
module mmio_uart_tx #(
    parameter int                        DATASIZE = 16,
    parameter int                        ADDRSIZE = 11,
    parameter logic [ADDRSIZE-1:0]       BASEADDR = 11'h7F0,
    parameter int                        CLKDIV   = 434,
    parameter int                        FIFOAW   = 2
) (
    input  logic                clock_i,
    input  logic                nreset_i,
    input  logic [ADDRSIZE-1:0] addr_i,
    input  logic [DATASIZE-1:0] data_i,
    input  logic                wr_i,
    input  logic                rd_i,
    output logic [DATASIZE-1:0] data_o,
    output logic                sel_o,
    output logic                tx_o
);

    localparam int                  DEPTH     = 1 << FIFOAW;
    localparam int                  BW        = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
    localparam logic [BW-1:0]       BCNT_LAST = BW'(CLKDIV - 1);
    localparam logic [ADDRSIZE-1:0] STAT_ADDR = BASEADDR + 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]        mem_q [DEPTH];
    logic [FIFOAW-1:0] wptr_q, rptr_q;
    logic [FIFOAW:0]   count_q, count_d;

    // Transmit FSM
    state_t            state_q, state_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;

    // Bus-side registers
    logic              ovf_q, ovf_d;
    logic [DATASIZE-1:0] data_q, data_d;
    logic              sel_q, sel_d;

    logic hit_data, hit_stat, full, empty, busy;
    logic push_req, push, pop, ovf_evt, bcnt_last;
    logic [2:0] cnt3;
    logic [DATASIZE-1:0] status;

    // The upper write-data byte has no destination.
    logic unused_hi;
    assign unused_hi = ^data_i[DATASIZE-1:8];

    assign hit_data  = (addr_i == BASEADDR);
    assign hit_stat  = (addr_i == STAT_ADDR);
    assign full      = (count_q == (FIFOAW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign busy      = (state_q != S_IDLE);
    assign bcnt_last = (bcnt_q == BCNT_LAST);
    assign cnt3      = 3'(count_q);

    // The FSM pops whenever it is idle and a byte is waiting.
    // That pop frees a slot, so a push can land on a full FIFO in the same cycle.
    assign pop      = (state_q == S_IDLE) && !empty;
    assign push_req = wr_i && hit_data;
    assign push     = push_req && (!full || pop);
    assign ovf_evt  = push_req && full && !pop;

    // FIFO occupancy, overflow flag and registered read data
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A STATUS read clears overflow, but a fresh overflow event takes priority.
        ovf_d = ovf_q;
        if (rd_i && hit_stat) ovf_d = 1'b0;
        if (ovf_evt)          ovf_d = 1'b1;

        // STATUS shows the state before this edge, so a same-cycle push is not counted.
        status      = '0;
        status[0]   = full;
        status[1]   = empty;
        status[2]   = busy;
        status[5:3] = cnt3;
        status[6]   = ovf_q;

        sel_d  = rd_i && (hit_data || hit_stat);
        data_d = (rd_i && hit_stat) ? status : '0;
    end

    // FIFO pointers, count, overflow and bus read registers
    always_ff @(posedge clock_i) begin
        if (!nreset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
            sel_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    // FIFO storage: only the pointers are reset, so stale contents are harmless
    always_ff @(posedge clock_i) begin
        if (push) mem_q[wptr_q] <= data_i[7:0];
    end

    // Transmit FSM next state. tx is derived from the next state so it is registered.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    shift_d = mem_q[rptr_q];
                    bcnt_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bcnt_last) begin
                    bcnt_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bcnt_last) begin
                    bcnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bcnt_last) begin
                    bcnt_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Transmit FSM registers; reset aborts any frame in flight and drives the line high
    always_ff @(posedge clock_i) begin
        if (!nreset_i) begin
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign data_o = data_q;
    assign sel_o  = sel_q;
    assign tx_o   = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx (CLKDIV=4). It applies a table of register
// accesses, then runs hand-written sequences for the single-byte frame,
// overflow, push-on-pop and mid-frame reset cases. A serial monitor decodes
// tx_o into rx_q, and rx_q is compared against exp_q.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam int CLKDIV = 4;
  localparam logic [10:0] BASE = 11'h7F0;
  localparam logic [10:0] STAT = 11'h7F1;

  logic        clk;
  logic        nreset;
  logic [10:0] addr;
  logic [15:0] wdata;
  logic        wr;
  logic        rd;
  logic [15:0] rdata;
  logic        sel;
  logic        tx;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  mmio_uart_tx #(
    .DATASIZE(16), .ADDRSIZE(11), .BASEADDR(11'h7F0), .CLKDIV(CLKDIV), .FIFOAW(2)
  ) dut (
    .clock_i (clk),
    .nreset_i(nreset),
    .addr_i  (addr),
    .data_i  (wdata),
    .wr_i    (wr),
    .rd_i    (rd),
    .data_o  (rdata),
    .sel_o   (sel),
    .tx_o    (tx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    addr = '0; wdata = '0; wr = 1'b0; rd = 1'b0;
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    idle_bus();
    cycle();
    cycle();
    check16("reset tx", {15'd0, tx}, 16'd1);
    check16("reset sel", {15'd0, sel}, 16'd0);
    check16("reset data", rdata, 16'h0000);
    nreset = 1'b1;
    exp_q.delete();
    rx_q.delete();
  endtask

  // serial monitor: sample mid-bit at negedge and decode 8N1 frames
  initial begin
    int mon_cnt;
    logic [7:0] sh;
    mon_cnt = -1;
    sh = 8'h00;
    forever begin
      @(negedge clk);
      if (nreset !== 1'b1) begin
        mon_cnt = -1;
      end else if (mon_cnt < 0) begin
        if (tx === 1'b0) mon_cnt = 0;
      end else begin
        mon_cnt++;
        if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % 4) == 2) sh = {tx, sh[7:1]};
        if (mon_cnt == 38) begin
          checks++;
          if (tx !== 1'b1) begin
            errors++;
            $display("FAIL stop_bit got %b expected 1", tx);
          end
          rx_q.push_back(sh);
          mon_cnt = -1;
        end
      end
    end
  end

  // scoreboard: wait (bounded) for expected bytes, then compare
  task automatic sb_check(input string name);
    int budget;
    int n;
    budget = 0;
    while (rx_q.size() < exp_q.size() && budget < 2000) begin
      cycle();
      budget++;
    end
    repeat (60) cycle();
    check16({name, " byte_count"}, 16'(rx_q.size()), 16'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check16({name, " byte"}, {8'h00, rx_q[i]}, {8'h00, exp_q[i]});
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  typedef struct {
    string       name;
    logic [10:0] addr;
    logic [15:0] data;
    logic        wr;
    logic        rd;
    logic        exp_sel;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [9:0] frame;
    logic       stayed_high;

    vecs[0] = '{"rd_status_after_reset", STAT,     16'h0000, 1'b0, 1'b1, 1'b1, 16'h0002};
    vecs[1] = '{"rd_txdata",             BASE,     16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000};
    vecs[2] = '{"rd_other",              11'h100,  16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[3] = '{"no_rd",                 STAT,     16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{"wr_status",             STAT,     16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[5] = '{"wr_other",              11'h7EF,  16'h00AA, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[6] = '{"status_no_push",        STAT,     16'h0000, 1'b0, 1'b1, 1'b1, 16'h0002};
    vecs[7] = '{"wr_rd_txdata",          BASE,     16'h12C3, 1'b1, 1'b1, 1'b1, 16'h0000};
    vecs[8] = '{"status_count1",         STAT,     16'h0000, 1'b0, 1'b1, 1'b1, 16'h0008};
    vecs[9] = '{"status_busy",           STAT,     16'h0000, 1'b0, 1'b1, 1'b1, 16'h0006};

    // register access table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      addr = vecs[i].addr; wdata = vecs[i].data; wr = vecs[i].wr; rd = vecs[i].rd;
      cycle();
      check16({vecs[i].name, " sel"}, {15'd0, sel}, {15'd0, vecs[i].exp_sel});
      check16({vecs[i].name, " data"}, rdata, vecs[i].exp_data);
    end
    idle_bus();
    exp_q.push_back(8'hC3);
    sb_check("table");

    // single byte: exact waveform, 4 clocks per bit
    do_reset();
    addr = BASE; wdata = 16'hAB55; wr = 1'b1;
    cycle();
    idle_bus();
    cycle();
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10 * CLKDIV; i++) begin
      if (i > 0) cycle();
      check16("frame_bit", {15'd0, tx}, {15'd0, frame[i / CLKDIV]});
      if (i == 20) begin
        check16("status_mid_frame", rdata, 16'h0006);
        rd = 1'b0;
      end
      if (i == 19) begin
        addr = STAT; rd = 1'b1;
      end
    end
    cycle();
    check16("idle_after_frame", {15'd0, tx}, 16'd1);
    addr = STAT; rd = 1'b1;
    cycle();
    check16("busy_cleared", rdata, 16'h0002);
    idle_bus();
    exp_q.push_back(8'h55);
    sb_check("single");

    // overflow: six back-to-back writes into a 4-deep FIFO
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      addr = BASE; wdata = {8'hEE, 8'(i)}; wr = 1'b1;
      cycle();
    end
    wr = 1'b0; addr = STAT; rd = 1'b1;
    cycle();
    check16("ovf_status_first", rdata, 16'h0065);
    cycle();
    check16("ovf_status_second", rdata, 16'h0025);
    addr = 11'h100;
    cycle();
    check16("rd_other sel", {15'd0, sel}, 16'd0);
    check16("rd_other data", rdata, 16'h0000);
    idle_bus();
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    sb_check("overflow");

    // push while full on the same edge as the idle pop
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      addr = BASE; wdata = {8'h00, 8'hA0 + 8'(i)}; wr = 1'b1;
      cycle();
    end
    idle_bus();
    repeat (37) cycle();
    addr = BASE; wdata = 16'h00A6; wr = 1'b1;
    cycle();
    wr = 1'b0; addr = STAT; rd = 1'b1;
    cycle();
    check16("push_on_pop_status", rdata, 16'h0025);
    idle_bus();
    for (int i = 1; i <= 6; i++) exp_q.push_back(8'hA0 + 8'(i));
    sb_check("push_on_pop");

    // reset in the middle of data bit 3 aborts the frame and flushes the FIFO
    do_reset();
    addr = BASE; wr = 1'b1;
    wdata = 16'h0000; cycle();
    wdata = 16'h0011; cycle();
    wdata = 16'h0022; cycle();
    idle_bus();
    repeat (16) cycle();
    check16("bit3_before_reset", {15'd0, tx}, 16'd0);
    nreset = 1'b0;
    cycle();
    check16("tx_high_after_reset", {15'd0, tx}, 16'd1);
    cycle();
    nreset = 1'b1;
    addr = STAT; rd = 1'b1;
    cycle();
    check16("status_after_abort", rdata, 16'h0002);
    idle_bus();
    stayed_high = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (tx !== 1'b1) stayed_high = 1'b0;
    end
    check16("no_frames_after_abort", {15'd0, stayed_high}, 16'd1);
    sb_check("abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
